apb_slave_ram: RTL and testbench

APB_SLAVE_RAM -- requirements
Module: apb_slave_ram

---
 rtl/apb_slave_pkg.sv | 16 +
 rtl/apb_slave_ram_if.sv | 26 ++
 rtl/apb_slave_mem_array.sv | 28 ++
 rtl/apb_slave_ram.sv | 129 ++++++++++++
 tb/tb_apb_slave_ram.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/apb_slave_pkg.sv
// rtl/apb_slave_pkg.sv - shared constants and FSM state encoding for the APB slave RAM
package apb_slave_pkg;

    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_WIDTH       = 32;
    localparam int DEF_DEPTH       = 64;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int CNT_WIDTH       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_slave_ram_if.sv
// rtl/apb_slave_ram_if.sv - APB bus bundle between master and the RAM slave
interface apb_slave_ram_if
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WIDTH      = DEF_WIDTH
);
    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic [WIDTH-1:0]      pwdata_i;
    logic [WIDTH-1:0]      prdata_o;
    logic                  pready_o;
    logic                  pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_slave_mem_array.sv
// rtl/apb_slave_mem_array.sv - single-port storage, synchronous write, registered read
module apb_slave_mem_array
    import apb_slave_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = 6
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Read register clears whenever no read is requested, so it doubles as the bus read-data output.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= re_i ? mem_q[addr_i] : '0;
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/apb_slave_ram.sv
// rtl/apb_slave_ram.sv - APB slave RAM with programmable wait states and range error
module apb_slave_ram
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic            pclk_i,
    input  logic            presetn_i,
    apb_slave_ram_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_RESP = RESP;
    localparam logic [CNT_WIDTH-1:0]  WAIT_C  = CNT_WIDTH'(WAIT_CYCLES);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]     addr_q, addr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic                 err_q, err_d;
    logic                 pready_q, pready_d;
    logic                 pslverr_q, pslverr_d;
    logic                 mem_we, mem_re, addr_err_in;
    logic [IDX_W-1:0]     mem_addr;

    assign addr_err_in = ({1'b0, bus.paddr_i} >= DEPTH_C);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        err_d     = err_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.psel_i && !bus.penable_i) begin
                    addr_d  = bus.paddr_i[IDX_W-1:0];
                    wdata_d = bus.pwdata_i;
                    write_d = bus.pwrite_i;
                    err_d   = addr_err_in;
                    if (WAIT_C == '0) begin
                        // No wait states: the response comes straight from the live setup inputs.
                        state_d   = ST_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = addr_err_in;
                        mem_re    = !bus.pwrite_i && !addr_err_in;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_C;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.psel_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_d   = ST_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        mem_re    = !write_q && !err_q;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                mem_we  = bus.psel_i && bus.penable_i && write_q && !err_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!presetn_i) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign mem_addr = (state_q == ST_IDLE) ? bus.paddr_i[IDX_W-1:0] : addr_q;

    apb_slave_mem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk_i   (pclk_i),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (wdata_q),
        .rdata_o (bus.prdata_o)
    );

    assign bus.pready_o  = pready_q;
    assign bus.pslverr_o = pslverr_q;
endmodule

// File: tb/tb_apb_slave_ram.sv
// tb/tb_apb_slave_ram.sv - directed bench for apb_slave_ram with 2 and 0 wait states
module tb_apb_slave_ram;
    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        psel[2], penable[2], pwrite[2];
    logic [7:0]  paddr[2];
    logic [31:0] pwdata[2];
    logic [31:0] rdata[2];
    logic        rdy[2], serr[2];

    apb_slave_ram_if #(.ADDR_WIDTH(8), .WIDTH(32)) bus0 ();
    apb_slave_ram_if #(.ADDR_WIDTH(8), .WIDTH(32)) bus1 ();

    assign bus0.psel_i = psel[0];  assign bus0.penable_i = penable[0];
    assign bus0.pwrite_i = pwrite[0];  assign bus0.paddr_i = paddr[0];
    assign bus0.pwdata_i = pwdata[0];
    assign bus1.psel_i = psel[1];  assign bus1.penable_i = penable[1];
    assign bus1.pwrite_i = pwrite[1];  assign bus1.paddr_i = paddr[1];
    assign bus1.pwdata_i = pwdata[1];
    assign rdata[0] = bus0.prdata_o;  assign rdy[0] = bus0.pready_o;  assign serr[0] = bus0.pslverr_o;
    assign rdata[1] = bus1.prdata_o;  assign rdy[1] = bus1.pready_o;  assign serr[1] = bus1.pslverr_o;

    apb_slave_ram #(.ADDR_WIDTH(8), .WIDTH(32), .DEPTH(64), .WAIT_CYCLES(2)) dut0 (
        .pclk_i(clk), .presetn_i(rstn), .bus(bus0));
    apb_slave_ram #(.ADDR_WIDTH(8), .WIDTH(32), .DEPTH(64), .WAIT_CYCLES(0)) dut1 (
        .pclk_i(clk), .presetn_i(rstn), .bus(bus1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_idle(input int w);
        @(negedge clk);
        psel[w] = 1'b0;
        penable[w] = 1'b0;
    endtask

    // One full transfer; returns right after the completion edge so a follow-on call is back-to-back.
    task automatic xfer(input int w, input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input bit scramble, output logic [31:0] rd, output logic err, output int lat);
        @(negedge clk);
        psel[w] = 1'b1; penable[w] = 1'b0; pwrite[w] = wr; paddr[w] = a; pwdata[w] = d;
        @(posedge clk);
        @(negedge clk);
        penable[w] = 1'b1;
        lat = 0;
        while (!rdy[w] && lat < 20) begin
            if (scramble) begin
                paddr[w] = ~a; pwdata[w] = ~d;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        rd  = rdata[w];
        err = serr[w];
        @(posedge clk);
    endtask

    task automatic do_wr(input int w, input logic [7:0] a, input logic [31:0] d,
                         input logic exp_err, input string tag, input bit scramble = 0);
        logic [31:0] rd; logic err; int lat;
        xfer(w, 1'b1, a, d, scramble, rd, err, lat);
        check({tag, "_lat"}, 32'(lat), (w == 0) ? 32'd2 : 32'd0);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic do_rd(input int w, input logic [7:0] a, input logic [31:0] exp_d,
                         input logic exp_err, input string tag);
        logic [31:0] rd; logic err; int lat;
        xfer(w, 1'b0, a, 32'h0, 1'b0, rd, err, lat);
        check({tag, "_lat"}, 32'(lat), (w == 0) ? 32'd2 : 32'd0);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_data"}, rd, exp_d);
    endtask

    logic [31:0] vals [10];
    int c0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            psel[i] = 0; penable[i] = 0; pwrite[i] = 0; paddr[i] = 0; pwdata[i] = 0;
        end
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_ready%0d", i), {31'd0, rdy[i]}, 32'd0);
            check($sformatf("rst_slverr%0d", i), {31'd0, serr[i]}, 32'd0);
            check($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
        end
        rstn = 1'b1;

        do_wr(0, 8'h05, 32'hDEADBEEF, 1'b0, "w2_wr05");
        do_rd(0, 8'h05, 32'hDEADBEEF, 1'b0, "w2_rd05");
        bus_idle(0);
        check("after_done_ready", {31'd0, rdy[0]}, 32'd0);
        check("after_done_rdata", rdata[0], 32'd0);

        do_wr(1, 8'h00, 32'h12345678, 1'b0, "w0_wr00");
        do_rd(1, 8'h00, 32'h12345678, 1'b0, "w0_rd00");
        bus_idle(1);

        do_wr(0, 8'h40, 32'hFFFFFFFF, 1'b1, "oob_wr40");
        do_rd(0, 8'h40, 32'h0, 1'b1, "oob_rd40");
        do_wr(0, 8'h3F, 32'hA5A55A5A, 1'b0, "edge_wr3f");
        do_rd(0, 8'h3F, 32'hA5A55A5A, 1'b0, "edge_rd3f");
        bus_idle(0);

        // Access strobe with no setup must not start a transfer.
        @(negedge clk);
        psel[0] = 1'b0; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h05; pwdata[0] = 32'h0;
        repeat (4) begin
            @(negedge clk);
            check("stray_penable_ready", {31'd0, rdy[0]}, 32'd0);
        end
        penable[0] = 1'b0;
        do_rd(0, 8'h05, 32'hDEADBEEF, 1'b0, "stray_rd05");
        bus_idle(0);

        do_wr(0, 8'h10, 32'h11111111, 1'b0, "abort_pre");
        bus_idle(0);
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h10; pwdata[0] = 32'h22222222;
        @(negedge clk);
        penable[0] = 1'b1;
        @(negedge clk);
        psel[0] = 1'b0; penable[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_wait_ready", {31'd0, rdy[0]}, 32'd0);
        end
        do_rd(0, 8'h10, 32'h11111111, 1'b0, "abort_wait_rd10");
        bus_idle(0);

        do_wr(1, 8'h10, 32'h33333333, 1'b0, "abortr_pre");
        bus_idle(1);
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h10; pwdata[1] = 32'h44444444;
        @(negedge clk);
        check("abortr_ready_up", {31'd0, rdy[1]}, 32'd1);
        psel[1] = 1'b0;
        @(negedge clk);
        check("abortr_ready_down", {31'd0, rdy[1]}, 32'd0);
        do_rd(1, 8'h10, 32'h33333333, 1'b0, "abortr_rd10");
        bus_idle(1);

        do_wr(0, 8'h20, 32'h55AA55AA, 1'b0, "rst_pre");
        bus_idle(0);
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h20; pwdata[0] = 32'h0BAD0BAD;
        @(negedge clk);
        penable[0] = 1'b1;
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_ready", {31'd0, rdy[0]}, 32'd0);
        check("midrst_slverr", {31'd0, serr[0]}, 32'd0);
        check("midrst_rdata", rdata[0], 32'd0);
        rstn = 1'b1; psel[0] = 1'b0; penable[0] = 1'b0;
        do_rd(0, 8'h20, 32'h55AA55AA, 1'b0, "midrst_rd20");
        bus_idle(0);

        do_wr(0, 8'h07, 32'h0BADF00D, 1'b0, "hold_wr07", 1'b1);
        do_rd(0, 8'h07, 32'h0BADF00D, 1'b0, "hold_rd07");
        do_rd(0, 8'hF8, 32'h0, 1'b1, "hold_rdf8");
        bus_idle(0);

        for (int i = 0; i < 10; i++) vals[i] = $urandom;
        do_wr(0, 8'h00, vals[0], 1'b0, "b2b_wr");
        c0 = cyc;
        do_rd(0, 8'h00, vals[0], 1'b0, "b2b_rd");
        for (int i = 1; i < 10; i++) begin
            do_wr(0, 8'(i), vals[i], 1'b0, "b2b_wr");
            do_rd(0, 8'(i), vals[i], 1'b0, "b2b_rd");
        end
        check("b2b_cycles", 32'(cyc - c0), 32'd76);
        bus_idle(0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
